// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the stream packet arbiter.
package stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam logic [1:0] CSR_ENABLE = 2'd0;
  localparam logic [1:0] CSR_STATUS = 2'd1;
  localparam logic [1:0] CSR_DROPS  = 2'd2;
  localparam logic [1:0] CSR_PKTS   = 2'd3;

  // Width of a port index; never below one bit.
  function automatic int grant_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first set request searching upward
// from ptr+1, wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW:0] slot;

  // Walk the candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    slot  = '0;
    for (int i = N; i >= 1; i--) begin
      slot = {1'b0, ptr} + (IW+1)'(i);
      if (slot >= (IW+1)'(N)) slot = slot - (IW+1)'(N);
      if (req[slot[IW-1:0]]) begin
        valid = 1'b1;
        idx   = slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS Avalon-ST inputs into
// one output stream, with an Avalon-MM CSR slave (enable mask, status, drop
// counter). Define STREAM_ARB_STATS_EN to add a wrapping packet counter at
// CSR address 3; otherwise that address reads 0.
module stream_packet_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_BYTES = 8,
  localparam int DW         = DATA_BYTES * 8,
  localparam int EW         = $clog2(DATA_BYTES),
  localparam int GW         = grant_idx_w(NUM_PORTS)
)(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0][DW-1:0]  in_data,
  input  logic [NUM_PORTS-1:0][EW-1:0]  in_empty,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS-1:0]          in_startofpacket,
  input  logic [NUM_PORTS-1:0]          in_endofpacket,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [DW-1:0]                 out_data,
  output logic [EW-1:0]                 out_empty,
  output logic                          out_valid,
  output logic                          out_startofpacket,
  output logic                          out_endofpacket,
  input  logic                          out_ready,
  input  logic [1:0]                    csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [31:0]                   csr_writedata,
  output logic [31:0]                   csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest
);

  localparam int DIW = $clog2(NUM_PORTS + 1);

  arb_state_e           state, state_nxt;
  logic [GW-1:0]        grant, ptr, pick_idx;
  logic                 pick_vld;
  logic [NUM_PORTS-1:0] enable, req, orphan;
  logic [DIW-1:0]       drop_inc;
  logic [31:0]          drop_count;
  logic [32:0]          drop_sum;
  logic [31:0]          pkt_count;
  logic [31:0]          rd_mux;
  logic                 win, drop_clr;
  logic                 unused_wdata;

  // Only packet starts compete; stray mid-packet words seen while idle are orphans.
  assign req      = in_valid & in_startofpacket & enable;
  assign orphan   = in_valid & ~in_startofpacket & enable;
  assign win      = (state == IDLE) && pick_vld;
  assign drop_clr = csr_write && (csr_address == CSR_DROPS);

  assign csr_waitrequest = 1'b0;
  assign unused_wdata    = ^csr_writedata;

  rr_pick #(.N(NUM_PORTS), .IW(GW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // State register; a win latches the grant and moves the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= GW'(NUM_PORTS - 1);
    end else begin
      state <= state_nxt;
      if (win) begin
        grant <= pick_idx;
        ptr   <= pick_idx;
      end
    end
  end

  // Next state plus the output mux: idle drives zeros, xfer passes the granted port through.
  always_comb begin
    state_nxt         = state;
    out_data          = '0;
    out_empty         = '0;
    out_valid         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    in_ready          = '0;
    case (state)
      IDLE: begin
        in_ready = orphan;
        if (pick_vld) state_nxt = XFER;
      end
      XFER: begin
        out_data          = in_data[grant];
        out_empty         = in_empty[grant];
        out_valid         = in_valid[grant];
        out_startofpacket = in_startofpacket[grant];
        out_endofpacket   = in_endofpacket[grant];
        in_ready[grant]   = out_ready;
        if (in_valid[grant] && out_ready && in_endofpacket[grant]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Count orphans dropped this cycle; several ports can drop at once.
  always_comb begin
    drop_inc = '0;
    if (state == IDLE) begin
      for (int p = 0; p < NUM_PORTS; p++) drop_inc = drop_inc + DIW'(orphan[p]);
    end
  end

  assign drop_sum = {1'b0, drop_count} + 33'(drop_inc);

  // Enable mask and saturating drop counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable     <= '1;
      drop_count <= '0;
    end else begin
      if (csr_write && (csr_address == CSR_ENABLE)) enable <= csr_writedata[NUM_PORTS-1:0];
      if (drop_clr)
        drop_count <= '0;
      else if (drop_inc != '0)
        drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end

`ifdef STREAM_ARB_STATS_EN
  // Wrapping packet counter, one per grant; a write clears it.
  always_ff @(posedge clk) begin
    if (!reset_n)
      pkt_count <= '0;
    else if (csr_write && (csr_address == CSR_PKTS))
      pkt_count <= '0;
    else if (win)
      pkt_count <= pkt_count + 32'd1;
  end
`else
  assign pkt_count = '0;
`endif

  // CSR read mux.
  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_ENABLE: rd_mux[NUM_PORTS-1:0] = enable;
      CSR_STATUS: begin
        rd_mux[31]  = (state == XFER);
        rd_mux[2:0] = 3'(grant);
      end
      CSR_DROPS:  rd_mux = drop_count;
      default:    rd_mux = pkt_count;
    endcase
  end

  // Fixed one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csr_readdatavalid <= 1'b0;
      csr_readdata      <= '0;
    end else begin
      csr_readdatavalid <= csr_read;
      if (csr_read) csr_readdata <= rd_mux;
    end
  end

endmodule
